// File: rtl/dualport_ram_be.sv
// Simple dual-port RAM with byte-lane writes, 1- or 2-cycle read latency, post-reset init sweep
// and a sticky address-range error. Define DUALPORT_BYPASS_EN for write-first collision reads.

module dualport_ram_lane #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef DUALPORT_BYPASS_EN
    assign rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
`else
    assign rd_data = mem[rd_addr];
`endif
endmodule

module dualport_ram_be #(
    parameter int              WIDTH    = 8,
    parameter int              DEPTH    = 16,
    parameter int              ADDR_W   = 4,
    parameter int              RD_LAT   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 rd_valid,
    output logic                 init_busy,
    output logic                 addr_err
);
    localparam int              NBE     = WIDTH / 8;
    localparam int              STAGES  = RD_LAT - 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                    state;
    logic [ADDR_W-1:0]         cnt;
    logic                      run;
    logic                      wr_in, rd_in, wr_ok, rd_req;
    logic [NBE-1:0]            lane_we;
    logic [ADDR_W-1:0]         waddr;
    logic [NBE-1:0][7:0]       wdata, rdata;
    logic [WIDTH-1:0]          rd_word;
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][WIDTH-1:0] rd_pipe;

    assign run    = (state == RUN);
    assign wr_in  = {1'b0, wr_addr} < DEPTH_C;
    assign rd_in  = {1'b0, rd_addr} < DEPTH_C;
    assign wr_ok  = run && write && wr_in;
    assign rd_req = run && read;

    // The init sweep borrows the write port until the FSM reaches RUN.
    always_comb begin
        waddr   = run ? wr_addr : cnt;
        wdata   = run ? data_in : INIT_VAL;
        lane_we = run ? (wr_ok ? wr_be : '0) : {NBE{!rst}};
    end

    for (genvar g = 0; g < NBE; g++) begin : g_lane
        dualport_ram_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
            .clk     (clk),
            .wr_en   (lane_we[g]),
            .wr_addr (waddr),
            .wr_data (wdata[g]),
            .rd_addr (rd_addr),
            .rd_data (rdata[g])
        );
    end

    assign rd_word = rd_in ? rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            addr_err <= 1'b0;
        else if (run && ((write && !wr_in) || (read && !rd_in)))
            addr_err <= 1'b1;
    end

    // Each stage only loads when the stage before it holds a read, so data_out holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            vld_pipe <= (STAGES+1)'({vld_pipe, rd_req});
            if (rd_req) rd_pipe[0] <= rd_word;
            for (int i = 1; i <= STAGES; i++)
                if (vld_pipe[i-1]) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign data_out = rd_pipe[STAGES];
    assign rd_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dualport_ram_be.sv
// Directed bench for dualport_ram_be: 32-bit, 12-deep, 2-cycle latency, with a read scoreboard.
module tb_dualport_ram_be;
    localparam int               WIDTH    = 32;
    localparam int               DEPTH    = 12;
    localparam int               ADDR_W   = 4;
    localparam int               RD_LAT   = 2;
    localparam int               NBE      = WIDTH / 8;
    localparam logic [WIDTH-1:0] INIT_VAL = 32'hA5A5_A5A5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write = 1'b0;
    logic [NBE-1:0]    wr_be = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              read = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [WIDTH-1:0]  data_out;
    logic              rd_valid;
    logic              init_busy;
    logic              addr_err;

    dualport_ram_be #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .wr_be(wr_be), .wr_addr(wr_addr),
        .data_in(data_in), .read(read), .rd_addr(rd_addr), .data_out(data_out),
        .rd_valid(rd_valid), .init_busy(init_busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] exp_mem [DEPTH];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding read, on its due cycle.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", data_out, e.data);
                chk("rd_latency", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_valid_missing", 32'd0, 32'd1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_init;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT_VAL;
    endtask

    task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic [NBE-1:0] be, input logic re, input logic [ADDR_W-1:0] ra);
        exp_t e;
        write = we; wr_addr = wa; data_in = wd; wr_be = be; read = re; rd_addr = ra;
        if (re) begin
            e.due = cyc + RD_LAT;
            if (int'(ra) >= DEPTH) begin
                e.data = '0;
            end else begin
                e.data = exp_mem[ra];
`ifdef DUALPORT_BYPASS_EN
                if (we && wa == ra)
                    for (int k = 0; k < NBE; k++) if (be[k]) e.data[8*k +: 8] = wd[8*k +: 8];
`endif
            end
            sb.push_back(e);
        end
        if (we && int'(wa) < DEPTH)
            for (int k = 0; k < NBE; k++) if (be[k]) exp_mem[wa][8*k +: 8] = wd[8*k +: 8];
        tick;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] ra);
        step(1'b0, '0, '0, '0, 1'b1, ra);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd, input logic [NBE-1:0] be);
        step(1'b1, wa, wd, be, 1'b0, '0);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1; write = 1'b0; read = 1'b0;
        sb.delete();
        repeat (n) tick;
        rst = 1'b0;
        model_init();
    endtask

    task automatic sweep_len(input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) tick;
    endtask

    initial begin
        logic [WIDTH-1:0] coll;
        tick; tick;
        chk("rst_data_out", data_out, 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
        chk("rst_init_busy", 32'(init_busy), 1);
        rst = 1'b0;
        model_init();

        // Requests issued during the sweep must be ignored entirely.
        write = 1'b1; wr_addr = 4'd0; data_in = 32'hDEAD_BEEF; wr_be = '1;
        read = 1'b1; rd_addr = 4'd15;
        sweep_len("init_sweep_len");
        write = 1'b0; read = 1'b0;
        chk("init_ignores_err", 32'(addr_err), 0);

        for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a));
        drain();

        wr(4'd3, 32'h1122_3344, 4'b1111);
        wr(4'd3, 32'hAABB_CCDD, 4'b0101);
        rd(4'd3);
        drain();
        chk("be_merge", data_out, 32'h11BB_33DD);

        wr(4'd3, 32'hFFFF_FFFF, 4'b0000);
        rd(4'd3);
        drain();
        chk("be_zero_noop", data_out, 32'h11BB_33DD);

        wr(4'd5, 32'h0000_000F, 4'b1111);
        step(1'b1, 4'd5, 32'h0000_00F0, 4'b1111, 1'b1, 4'd5);
        rd(4'd5);
        drain();
        chk("collision_after", data_out, 32'h0000_00F0);

        wr(4'd2, 32'h0000_1234, 4'b1111);
        step(1'b1, 4'd2, 32'h0000_ABCD, 4'b0010, 1'b1, 4'd2);
        drain();
`ifdef DUALPORT_BYPASS_EN
        coll = 32'h0000_AB34;
`else
        coll = 32'h0000_1234;
`endif
        chk("collision_partial", data_out, coll);
        rd(4'd2);
        drain();
        chk("collision_partial_after", data_out, 32'h0000_AB34);

        step(1'b1, 4'd7, 32'hCAFE_F00D, 4'b1111, 1'b1, 4'd3);
        rd(4'd7);
        drain();
        chk("indep_ports", data_out, 32'hCAFE_F00D);

        chk("err_clear_before", 32'(addr_err), 0);
        wr(4'd13, 32'hDEAD_BEEF, 4'b1111);
        tick;
        chk("wr_range_err", 32'(addr_err), 1);
        rd(4'd13);
        rd(4'd12);
        rd(4'd1);
        wr(4'd11, 32'h0BAD_CAFE, 4'b1111);
        rd(4'd11);
        drain();
        repeat (5) tick;
        chk("err_sticky", 32'(addr_err), 1);

        // Reset with a read in flight: the strobe must never appear.
        rd(4'd7);
        apply_reset(1);
        chk("rst_flush_data", data_out, 0);
        chk("rst_clears_err", 32'(addr_err), 0);

        repeat (7) tick;
        apply_reset(1);
        sweep_len("sweep_restart_len");

        rd(4'd3);
        rd(4'd7);
        rd(4'd11);
        drain();
        chk("resweep_data", data_out, INIT_VAL);

        rd(4'd15);
        drain();
        chk("rd_range_data", data_out, 0);
        chk("rd_range_err", 32'(addr_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
